pipeline_hazard_controller: RTL and testbench

Sequences the 5-stage MIPS pipeline around hazards that operand forwarding cannot resolve.
- Detects load-use dependencies and inserts a one-cycle bubble.
- Freezes the front of the pipe while a multi-cycle multiply/divide occupies EX.
- Flushes IF/ID on a taken branch or jump resolved in ID.
- Sits beside the forwarding unit and drives PC, IF/ID and ID/EX write/bubble controls.

---
 rtl/pipeline_hazard_controller.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a 5-stage MIPS pipe: load-use bubbles, mul/div freeze
// of the front end, IF/ID flush on taken branches, and a saturating stall counter.
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RT_EX,
  input  logic [4:0]       RS_ID,
  input  logic [4:0]       RT_ID,
  input  logic             UsesRT_ID,
  input  logic             BranchTaken_ID,
  input  logic             MulDivStart_EX,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic             MD_Done,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       load_use;
  logic       md_hold;

  assign load_use = MemRead_EX && (RT_EX != 5'd0) &&
                    ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));

  // While the counter is non-zero the mul/div owns EX; at zero the final
  // cycle behaves like RUN so a new operation can start back-to-back.
  assign md_hold = (state == MD_BUSY) && (md_cnt != 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt  = RUN;
    md_cnt_nxt = 4'd0;
    if (md_hold) begin
      state_nxt  = MD_BUSY;
      md_cnt_nxt = md_cnt - 4'd1;
    end else if (MulDivStart_EX) begin
      state_nxt  = MD_BUSY;
      md_cnt_nxt = MD_LOAD;
    end
  end

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MD_Done       = (state == MD_BUSY) && (md_cnt == 4'd0);

    if (md_hold || MulDivStart_EX) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Bubble = 1'b1;
    end else if (load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (BranchTaken_ID) begin
      IF_ID_Flush = 1'b1;
    end

    // Reset forces a safe pipe regardless of state or inputs.
    if (!reset) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b0;
      MD_Done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
    end else if (!PCWrite && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: load-use, branch flush,
// mul/div freeze (single and back-to-back), reset abort and counter saturation.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic        MemRead_EX;
  logic [4:0]  RT_EX;
  logic [4:0]  RS_ID;
  logic [4:0]  RT_ID;
  logic        UsesRT_ID;
  logic        BranchTaken_ID;
  logic        MulDivStart_EX;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Write;
  logic        ID_EX_Bubble;
  logic        EX_MEM_Bubble;
  logic        MD_Done;
  logic [15:0] StallCount;

  int vectors    = 0;
  int miscompares = 0;

  // Control vector order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
  // ID_EX_Bubble, EX_MEM_Bubble, MD_Done.
  localparam logic [6:0] V_RUN   = 7'b1101000;
  localparam logic [6:0] V_LU    = 7'b0001100;
  localparam logic [6:0] V_MD    = 7'b0000010;
  localparam logic [6:0] V_RST   = 7'b0011100;
  localparam logic [6:0] V_BR    = 7'b1111000;
  localparam logic [6:0] V_DONE  = 7'b1101001;
  localparam logic [6:0] V_DONE2 = 7'b0000011;

  pipeline_hazard_controller #(.MULDIV_CYCLES(4), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead_EX     (MemRead_EX),
    .RT_EX          (RT_EX),
    .RS_ID          (RS_ID),
    .RT_ID          (RT_ID),
    .UsesRT_ID      (UsesRT_ID),
    .BranchTaken_ID (BranchTaken_ID),
    .MulDivStart_EX (MulDivStart_EX),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Write    (ID_EX_Write),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .EX_MEM_Bubble  (EX_MEM_Bubble),
    .MD_Done        (MD_Done),
    .StallCount     (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
           ID_EX_Bubble, EX_MEM_Bubble, MD_Done};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
    vectors++;
    assert (StallCount === exp) else begin
      miscompares++;
      $error("FAIL %s: observed StallCount %h expected %h", tag, StallCount, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead_EX     = 1'b0;
    RT_EX          = 5'd0;
    RS_ID          = 5'd3;
    RT_ID          = 5'd9;
    UsesRT_ID      = 1'b0;
    BranchTaken_ID = 1'b0;
    MulDivStart_EX = 1'b0;
  endtask

  initial begin
    // Reset held with hazard-looking inputs: outputs must stay forced.
    reset = 1'b0;
    idle_inputs();
    MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5; BranchTaken_ID = 1'b1;
    #2;
    check_ctl("reset_forced", V_RST);
    check_cnt("reset_cnt", 16'd0);
    cyc();
    check_ctl("reset_forced_edge", V_RST);
    check_cnt("reset_cnt_edge", 16'd0);

    // Release, no hazards.
    reset = 1'b1;
    idle_inputs();
    check_ctl("run_default", V_RUN);
    cyc();
    check_cnt("run_cnt", 16'd0);

    // Load-use via rs.
    MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5;
    check_ctl("lu_rs", V_LU);
    cyc();
    idle_inputs();
    check_ctl("lu_rs_clear", V_RUN);
    check_cnt("lu_rs_cnt", 16'd1);

    // Register 0 never hazards.
    MemRead_EX = 1'b1; RT_EX = 5'd0; RS_ID = 5'd0; RT_ID = 5'd0; UsesRT_ID = 1'b1;
    check_ctl("lu_r0", V_RUN);
    cyc();

    // rt match only counts when the ID instruction reads rt.
    idle_inputs();
    MemRead_EX = 1'b1; RT_EX = 5'd7; RT_ID = 5'd7; UsesRT_ID = 1'b0;
    check_ctl("lu_rt_unused", V_RUN);
    check_cnt("lu_r0_cnt", 16'd1);
    cyc();
    UsesRT_ID = 1'b1;
    check_ctl("lu_rt_used", V_LU);
    cyc();
    idle_inputs();
    check_ctl("lu_rt_clear", V_RUN);
    check_cnt("lu_rt_cnt", 16'd2);

    // Branch flush, and load-use outranks it.
    BranchTaken_ID = 1'b1;
    check_ctl("branch_flush", V_BR);
    cyc();
    MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5;
    check_ctl("lu_over_branch", V_LU);
    cyc();

    // Single mul/div starting at T.
    idle_inputs();
    MulDivStart_EX = 1'b1;
    check_ctl("md_T", V_MD);
    check_cnt("md_pre_cnt", 16'd3);
    cyc();
    MulDivStart_EX = 1'b0;
    BranchTaken_ID = 1'b1; MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5;
    check_ctl("md_T1_ignore", V_MD);
    cyc();
    idle_inputs();
    check_ctl("md_T2", V_MD);
    cyc();
    check_ctl("md_T3_done", V_DONE);
    check_cnt("md_cnt", 16'd6);
    cyc();
    check_ctl("md_after", V_RUN);
    cyc();

    // Back-to-back: second start coincides with first done.
    MulDivStart_EX = 1'b1;
    check_ctl("b2b_T", V_MD);
    cyc();
    MulDivStart_EX = 1'b0;
    check_ctl("b2b_T1", V_MD);
    cyc();
    check_ctl("b2b_T2", V_MD);
    cyc();
    MulDivStart_EX = 1'b1;
    check_ctl("b2b_T3_done_start", V_DONE2);
    cyc();
    MulDivStart_EX = 1'b0;
    check_ctl("b2b_T4", V_MD);
    cyc();
    check_ctl("b2b_T5", V_MD);
    cyc();
    check_ctl("b2b_T6_done", V_DONE);
    check_cnt("b2b_cnt", 16'd12);
    cyc();
    check_ctl("b2b_after", V_RUN);
    cyc();

    // Reset in the middle of a mul/div aborts it.
    MulDivStart_EX = 1'b1;
    check_ctl("abort_T", V_MD);
    cyc();
    MulDivStart_EX = 1'b0;
    reset = 1'b0;
    check_ctl("abort_forced", V_RST);
    check_cnt("abort_cnt", 16'd0);
    cyc();
    reset = 1'b1;
    check_ctl("abort_release", V_RUN);
    cyc();
    check_ctl("abort_no_done", V_RUN);
    check_cnt("abort_cnt_after", 16'd0);

    // Saturation: hold a load-use hazard well past 2^16 cycles.
    MemRead_EX = 1'b1; RT_EX = 5'd5; RS_ID = 5'd5;
    repeat (65540) cyc();
    check_ctl("sat_lu", V_LU);
    check_cnt("sat_cnt", 16'hFFFF);
    cyc();
    check_cnt("sat_hold", 16'hFFFF);
    idle_inputs();
    check_ctl("sat_clear", V_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
